vga_pixel_pipe: RTL and testbench

Display-side pixel pipeline between the `vga` timing generator and the VGA pins. It turns the raster position (`row`, `col`) into a frame-buffer read address and issues reads to the live, static and Sobel BRAMs. It delays `HS`/`VS`/`blank`/`draw_box` by the full read latency so that sync and colour stay aligned, and it applies the box overlay. Source selection changes only at frame boundaries, so switch changes never tear a displayed frame.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/delay_line.sv | 32 +++
 rtl/vga_pixel_pipe.sv | 189 ++++++++++++++++++
 tb/tb_vga_pixel_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA display pixel pipeline.
// Source codes, selection FSM states and raster geometry.
package vga_pkg;

  typedef enum logic [1:0] {
    SRC_LIVE,
    SRC_STATIC,
    SRC_SOBEL,
    SRC_RAMP
  } pix_src_t;

  typedef enum logic {
    STABLE,
    PENDING
  } sel_state_t;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int FRAME_PIXELS = 307200;

endpackage

// File: rtl/delay_line.sv
// Synchronous-reset shift register of DEPTH stages.
// Every stage parks at RESET_VAL while reset is high.
module delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Advance one stage per clock; reset clears all stages to idle
  always_ff @(posedge clk_50) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_pipe.sv
// Raster position to BRAM address, latency-matched sync and colour,
// box overlay and frame-synchronous source selection.
module vga_pixel_pipe #(
  parameter int READ_LAT = 1,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic [9:0]  row,
  input  logic [9:0]  col,
  input  logic        HS,
  input  logic        VS,
  input  logic        blank,
  input  logic        draw_box,
  input  logic [1:0]  sel_req,
  input  logic [3:0]  pix_live,
  input  logic [3:0]  pix_static,
  input  logic [3:0]  pix_sobel,
  output logic [18:0] frame_addr,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start,
  output logic [1:0]  sel_active,
  output logic [7:0]  frame_count
);

  import vga_pkg::*;

  localparam int         DLY   = 1 + READ_LAT;
  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

  logic [18:0] row_x;
  logic [18:0] col_x;
  logic [18:0] addr_sum;
  logic        in_active;

  assign row_x     = {9'd0, row};
  assign col_x     = {9'd0, col};
  assign addr_sum  = (row_x << 9) + (row_x << 7) + col_x;
  assign in_active = (row < V_LIM) && (col < H_LIM);

  // Stage A: row*640+col by shift-add, parked at 0 off-screen
  always_ff @(posedge clk_50) begin
    if (reset) begin
      frame_addr <= '0;
    end else begin
      frame_addr <= in_active ? addr_sum : '0;
    end
  end

  logic [9:0] row_q;

  // Previous row, used to spot the wrap back to line 0
  always_ff @(posedge clk_50) begin
    if (reset) begin
      row_q <= '0;
    end else begin
      row_q <= row;
    end
  end

  assign frame_start = !reset && (row_q != '0) && (row == '0);

  // Frames started since reset, wrapping at 256
  always_ff @(posedge clk_50) begin
    if (reset) begin
      frame_count <= '0;
    end else if (frame_start) begin
      frame_count <= frame_count + 8'd1;
    end
  end

  sel_state_t state;
  sel_state_t state_n;
  logic [1:0] sel_n;

  // Selection state and committed source
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state      <= STABLE;
      sel_active <= 2'(SRC_STATIC);
    end else begin
      state      <= state_n;
      sel_active <= sel_n;
    end
  end

  // Hold a request until the next frame boundary, then commit
  always_comb begin
    state_n = state;
    sel_n   = sel_active;
    unique case (state)
      STABLE: begin
        if (sel_req != sel_active) begin
          state_n = PENDING;
        end
      end
      PENDING: begin
        if (frame_start) begin
          sel_n   = sel_req;
          state_n = STABLE;
        end else if (sel_req == sel_active) begin
          state_n = STABLE;
        end
      end
    endcase
  end

  logic [3:0] ctl_d;
  logic [1:0] sel_d;
  logic [3:0] col_d;

  delay_line #(
    .WIDTH     (4),
    .DEPTH     (DLY),
    .RESET_VAL (4'b1110)
  ) u_ctl_dly (
    .clk_50 (clk_50),
    .reset  (reset),
    .din    ({HS, VS, blank, draw_box}),
    .dout   (ctl_d)
  );

  delay_line #(
    .WIDTH     (2),
    .DEPTH     (DLY),
    .RESET_VAL (2'(SRC_STATIC))
  ) u_sel_dly (
    .clk_50 (clk_50),
    .reset  (reset),
    .din    (sel_n),
    .dout   (sel_d)
  );

  delay_line #(
    .WIDTH     (4),
    .DEPTH     (DLY),
    .RESET_VAL (4'd0)
  ) u_col_dly (
    .clk_50 (clk_50),
    .reset  (reset),
    .din    (col[9:6]),
    .dout   (col_d)
  );

  logic [3:0] pix_sel;
  logic [3:0] colour;

  // Source mux and overlay priority: blank, then box, then pixel
  always_comb begin
    pix_sel = '0;
    unique case (pix_src_t'(sel_d))
      SRC_LIVE:   pix_sel = pix_live;
      SRC_STATIC: pix_sel = pix_static;
      SRC_SOBEL:  pix_sel = pix_sobel;
      SRC_RAMP:   pix_sel = col_d;
    endcase
    if (ctl_d[1]) begin
      colour = 4'h0;
    end else if (ctl_d[0]) begin
      colour = 4'hF;
    end else begin
      colour = pix_sel;
    end
  end

  // Stage C output register: grayscale colour and delayed sync
  always_ff @(posedge clk_50) begin
    if (reset) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      vga_r  <= colour;
      vga_g  <= colour;
      vga_b  <= colour;
      vga_hs <= ctl_d[3];
      vga_vs <= ctl_d[2];
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Bench for vga_pixel_pipe at READ_LAT 1 and 2 side by side.
// Outputs are compared with a cycle model kept in queues.
module tb_vga_pixel_pipe;

  typedef struct packed {
    logic [3:0] c;
    logic       hs;
    logic       vs;
  } exp_t;

  localparam exp_t IDLE = '{c: 4'h0, hs: 1'b1, vs: 1'b1};

  logic        clk_50;
  logic        reset;
  logic [9:0]  row;
  logic [9:0]  col;
  logic        HS;
  logic        VS;
  logic        blank;
  logic        draw_box;
  logic [1:0]  sel_req;

  logic [3:0]  lv1, st1, sb1;
  logic [18:0] addr1;
  logic [3:0]  r1, g1, b1;
  logic        hs1, vs1, fs1;
  logic [1:0]  sel1;
  logic [7:0]  cnt1;

  logic [3:0]  lv2, st2, sb2;
  logic [18:0] addr2;
  logic [18:0] a2d;
  logic [3:0]  r2, g2, b2;
  logic        hs2, vs2, fs2;
  logic [1:0]  sel2;
  logic [7:0]  cnt2;

  int passed;
  int total;
  int pulses;

  exp_t q1[$];
  exp_t q2[$];

  logic [1:0]  m_act;
  logic [1:0]  m_prev_req;
  logic [9:0]  m_prev_row;
  logic [7:0]  m_cnt;

  vga_pixel_pipe #(.READ_LAT(1)) dut1 (
    .clk_50      (clk_50),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .HS          (HS),
    .VS          (VS),
    .blank       (blank),
    .draw_box    (draw_box),
    .sel_req     (sel_req),
    .pix_live    (lv1),
    .pix_static  (st1),
    .pix_sobel   (sb1),
    .frame_addr  (addr1),
    .vga_r       (r1),
    .vga_g       (g1),
    .vga_b       (b1),
    .vga_hs      (hs1),
    .vga_vs      (vs1),
    .frame_start (fs1),
    .sel_active  (sel1),
    .frame_count (cnt1)
  );

  vga_pixel_pipe #(.READ_LAT(2)) dut2 (
    .clk_50      (clk_50),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .HS          (HS),
    .VS          (VS),
    .blank       (blank),
    .draw_box    (draw_box),
    .sel_req     (sel_req),
    .pix_live    (lv2),
    .pix_static  (st2),
    .pix_sobel   (sb2),
    .frame_addr  (addr2),
    .vga_r       (r2),
    .vga_g       (g2),
    .vga_b       (b2),
    .vga_hs      (hs2),
    .vga_vs      (vs2),
    .frame_start (fs2),
    .sel_active  (sel2),
    .frame_count (cnt2)
  );

  function automatic logic [3:0] f_live(input logic [18:0] a);
    return a[3:0] ^ 4'h5;
  endfunction

  function automatic logic [3:0] f_static(input logic [18:0] a);
    return a[3:0];
  endfunction

  function automatic logic [3:0] f_sobel(input logic [18:0] a);
    return a[7:4];
  endfunction

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  // BRAM models: one and two cycles of read latency
  always @(posedge clk_50) begin
    lv1 <= f_live(addr1);
    st1 <= f_static(addr1);
    sb1 <= f_sobel(addr1);
    a2d <= addr2;
    lv2 <= f_live(a2d);
    st2 <= f_static(a2d);
    sb2 <= f_sobel(a2d);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic chk_pix(input string tg, input exp_t e,
                         input logic [3:0] r, input logic [3:0] g,
                         input logic [3:0] b, input logic hs,
                         input logic vs);
    chk({tg, "_r"}, 32'(r), 32'(e.c));
    chk({tg, "_g"}, 32'(g), 32'(e.c));
    chk({tg, "_b"}, 32'(b), 32'(e.c));
    chk({tg, "_hs"}, 32'(hs), 32'(e.hs));
    chk({tg, "_vs"}, 32'(vs), 32'(e.vs));
  endtask

  task automatic step(input logic rs, input logic [9:0] rw,
                      input logic [9:0] cl, input logic hs_i,
                      input logic vs_i, input logic bl,
                      input logic bx, input logic [1:0] sr);
    logic        fs;
    logic [1:0]  act_n;
    logic [18:0] a;
    exp_t        e;
    exp_t        o1;
    exp_t        o2;
    reset    = rs;
    row      = rw;
    col      = cl;
    HS       = hs_i;
    VS       = vs_i;
    blank    = bl;
    draw_box = bx;
    sel_req  = sr;
    #1;
    fs = (m_prev_row != 10'd0) && (rw == 10'd0);
    if (!rs) begin
      chk("frame_start_l1", 32'(fs1), 32'(fs));
      chk("frame_start_l2", 32'(fs2), 32'(fs));
      if (fs1) pulses++;
    end
    act_n = (fs && m_prev_req != m_act) ? sr : m_act;
    if (rw < 10'd480 && cl < 10'd640) begin
      a = 19'(int'(rw) * 640 + int'(cl));
    end else begin
      a = '0;
    end
    e.hs = hs_i;
    e.vs = vs_i;
    if (bl) begin
      e.c = 4'h0;
    end else if (bx) begin
      e.c = 4'hF;
    end else begin
      case (act_n)
        2'd0:    e.c = f_live(a);
        2'd1:    e.c = f_static(a);
        2'd2:    e.c = f_sobel(a);
        default: e.c = cl[9:6];
      endcase
    end
    @(posedge clk_50);
    #1;
    if (rs) begin
      o1 = IDLE;
      o2 = IDLE;
      q1 = {};
      q2 = {};
      for (int i = 0; i < 2; i++) q1.push_back(IDLE);
      for (int i = 0; i < 3; i++) q2.push_back(IDLE);
      m_act      = 2'd1;
      m_prev_req = 2'd1;
      m_prev_row = '0;
      m_cnt      = '0;
      a          = '0;
    end else begin
      o1 = q1.pop_front();
      o2 = q2.pop_front();
      q1.push_back(e);
      q2.push_back(e);
      m_act      = act_n;
      m_prev_req = sr;
      m_prev_row = rw;
      if (fs) m_cnt = m_cnt + 8'd1;
    end
    chk_pix("pix_l1", o1, r1, g1, b1, hs1, vs1);
    chk_pix("pix_l2", o2, r2, g2, b2, hs2, vs2);
    chk("addr_l1", 32'(addr1), 32'(a));
    chk("addr_l2", 32'(addr2), 32'(a));
    chk("sel_l1", 32'(sel1), 32'(m_act));
    chk("sel_l2", 32'(sel2), 32'(m_act));
    chk("count_l1", 32'(cnt1), 32'(m_cnt));
    chk("count_l2", 32'(cnt2), 32'(m_cnt));
  endtask

  task automatic pix(input logic [9:0] rw, input logic [9:0] cl,
                     input logic hs_i, input logic vs_i,
                     input logic bl, input logic bx,
                     input logic [1:0] sr);
    step(1'b0, rw, cl, hs_i, vs_i, bl, bx, sr);
    step(1'b0, rw, cl, hs_i, vs_i, bl, bx, sr);
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    pulses     = 0;
    m_act      = 2'd1;
    m_prev_req = 2'd1;
    m_prev_row = '0;
    m_cnt      = '0;

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
    end
    chk("reset_fs", 32'(fs1), 32'd0);

    step(1'b0, 10'd2, 10'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    chk("addr_2_5", 32'(addr1), 32'd1285);
    step(1'b0, 10'd479, 10'd639, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    chk("addr_max", 32'(addr2), 32'd307199);
    step(1'b0, 10'd480, 10'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    chk("addr_off", 32'(addr1), 32'd0);

    for (int c = 0; c < 8; c++) begin
      pix(10'd0, 10'(c), c[0], 1'b1, 1'b0, 1'b0, 2'd1);
    end

    pix(10'd3, 10'd10, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
    pix(10'd3, 10'd11, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1);
    for (int i = 0; i < 3; i++) begin
      pix(10'd3, 10'd12, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    end

    for (int i = 0; i < 3; i++) begin
      pix(10'd5, 10'(20 + i), 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
    end
    chk("sel_hold", 32'(sel1), 32'd1);
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
    chk("sel_commit", 32'(sel1), 32'd2);
    for (int i = 0; i < 4; i++) begin
      pix(10'd0, 10'(i), 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
    end

    pix(10'd5, 10'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    chk("sel_back", 32'(sel2), 32'd1);
    pix(10'd5, 10'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
    pix(10'd5, 10'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    pix(10'd5, 10'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    chk("sel_toggle", 32'(sel1), 32'd1);
    pix(10'd5, 10'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
    chk("sel_same_cycle", 32'(sel1), 32'd1);
    pix(10'd5, 10'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
    chk("sel_next_frame", 32'(sel1), 32'd2);

    step(1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
    pulses = 0;
    for (int f = 0; f < 256; f++) begin
      pix(10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
      pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    end
    chk("wrap_count", 32'(cnt1), 32'd0);
    chk("wrap_pulses", 32'(pulses), 32'd256);

    pix(10'd100, 10'd200, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
    pix(10'd100, 10'd201, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
    step(1'b1, 10'd100, 10'd202, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
    chk("rst_mid_r", 32'(r1), 32'd0);
    chk("rst_mid_hs", 32'(hs1), 32'd1);
    chk("rst_mid_vs", 32'(vs2), 32'd1);
    chk("rst_mid_sel", 32'(sel2), 32'd1);

    begin
      logic [9:0] rw;
      logic [1:0] sr;
      sr = 2'd1;
      rw = 10'd1;
      for (int n = 0; n < 1500; n++) begin
        if (n % 8 == 0) begin
          rw = ($urandom_range(0, 3) == 0) ? 10'd0
             : 10'($urandom_range(1, 524));
        end
        if ($urandom_range(0, 15) == 0) sr = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 299) == 0) begin
          step(1'b1, rw, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, sr);
        end else begin
          pix(rw, 10'($urandom_range(0, 799)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 7) == 0), sr);
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
